rtc_bus_sequencer: RTL and testbench
====================================

RTC_BUS_SEQUENCER -- requirements
Module: rtc_bus_sequencer

Interface
REQ-001 SHALL provide parameters, one per line (name, default, meaning):
  DATA_W   8   multiplexed address/data bus width
  BURST_W  4   burst length field width
  T_SU     2   setup cycles per phase, minimum 1
  T_PW     4   strobe low cycles per phase, minimum 1
  T_HD     2   hold cycles per phase, minimum 1
  T_REC    3   CS-high recovery cycles after each beat, minimum 1
REQ-002 SHALL have these ports, one per line (name, direction, width, meaning):
  clk         in   1        single clock
  reset       in   1        asynchronous, active-low reset
  start       in   1        transfer request, 1-cycle pulse
  rw          in   1        1 = read, 0 = write; sampled with start
  addr        in   DATA_W   first register address; sampled with start
  burst_len   in   BURST_W  beat count; sampled with start; 0 means 1
  wdata       in   DATA_W   write data; sampled on DATA_SETUP entry
  bus_in      in   DATA_W   RTC bus read-back
  bus_out     out  DATA_W   RTC bus drive value
  bus_oe      out  1        bus drive enable (1 = drive)
  A_D         out  1        0 = address phase, 1 = data phase
  CS          out  1        chip select, active-low
  RD          out  1        read strobe, active-low
  WR          out  1        write strobe, active-low
  busy        out  1        transfer in progress
  next_req    out  1        1-cycle request for next beat's wdata
  rdata       out  DATA_W   last read value
  rdata_valid out  1        1-cycle pulse when rdata updates
  done        out  1        1-cycle end-of-transfer pulse

Function
REQ-003 SHALL implement states IDLE, ADDR_SU, ADDR_PW, ADDR_HD, DATA_SU, DATA_PW, DATA_HD, RECOV.
REQ-004 Each timed state SHALL last exactly its parameter count in cycles, using one shared down-counter.
REQ-005 Idle levels SHALL be: CS=1, RD=1, WR=1, A_D=1, bus_oe=0, bus_out=0, busy=0.
REQ-006 start in IDLE SHALL latch rw, addr and burst_len; the next cycle SHALL enter ADDR_SU with busy=1.
REQ-007 start SHALL be ignored while busy=1.
REQ-008 Address phase (ADDR_SU/PW/HD): CS=0, A_D=0, bus_oe=1, bus_out=current address; WR=0 only in ADDR_PW; RD=1 throughout.
REQ-009 Data phase (DATA_SU/PW/HD): CS=0, A_D=1.
REQ-010 Data phase, write: bus_oe=1, bus_out=wdata captured on DATA_SU entry; WR=0 only in DATA_PW.
REQ-011 Data phase, read: bus_oe=0; RD=0 only in DATA_PW.
REQ-012 Read capture: bus_in SHALL be registered into rdata on the last DATA_PW cycle; rdata_valid SHALL pulse the following cycle.
REQ-013 RECOV: CS=1, bus_oe=0.
REQ-014 At RECOV end with beats remaining: address SHALL increment modulo 2^DATA_W (0xFF -> 0x00 at DATA_W=8) and the FSM SHALL enter ADDR_SU.
REQ-015 next_req SHALL pulse on each ADDR_SU entry of beats 2..N, for writes only.
REQ-016 done SHALL pulse on the final RECOV cycle of the last beat; busy SHALL fall the next cycle, returning to IDLE.
REQ-017 start in the same cycle as done SHALL be ignored.
REQ-018 A_D, CS, RD, WR and bus_oe SHALL be registered outputs (glitch-free).
REQ-019 RD and WR SHALL never both be 0 in the same cycle.

Reset
REQ-020 reset=0 SHALL asynchronously force IDLE with idle levels, rdata=0, and done, rdata_valid and next_req all 0, including mid-transfer.
REQ-021 Operation SHALL resume on the first clk edge after reset deasserts.

Verification
REQ-022 Single write, defaults, addr=0x21, wdata=0x15, burst_len=1 -> busy for 19 cycles; WR low in 2 windows of 4 cycles; bus_out=0x21 then 0x15; done on busy cycle 19.
REQ-023 Single read, addr=0x22, bus_in=0x37 -> RD low 4 cycles and WR low only in the address phase; rdata=0x37 with one rdata_valid pulse; bus_oe=0 in the data phase.
REQ-024 Burst write, addr=0xFE, burst_len=3 -> addresses 0xFE, 0xFF, 0x00; 2 next_req pulses; CS high 3 cycles between beats; 1 done.
REQ-025 burst_len=0 -> behaves exactly as burst_len=1.
REQ-026 reset=0 asserted during DATA_PW of a write -> same-cycle CS=1, WR=1, bus_oe=0, busy=0; a new start after release completes normally.
REQ-027 start pulsed while busy, and start coincident with done -> both ignored; the transfer count is unchanged.

Source files
------------

// File: rtl/rtc_bus_sequencer.sv
// Multiplexed address/data bus master for an RTC chip: every beat runs an address phase,
// a data phase and a CS-high recovery, each phase timed as setup / strobe / hold.
module rtc_bus_sequencer #(
  parameter int DATA_W  = 8,
  parameter int BURST_W = 4,
  parameter int T_SU    = 2,
  parameter int T_PW    = 4,
  parameter int T_HD    = 2,
  parameter int T_REC   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               rw,
  input  logic [DATA_W-1:0]  addr,
  input  logic [BURST_W-1:0] burst_len,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [DATA_W-1:0]  bus_in,
  output logic [DATA_W-1:0]  bus_out,
  output logic               bus_oe,
  output logic               A_D,
  output logic               CS,
  output logic               RD,
  output logic               WR,
  output logic               busy,
  output logic               next_req,
  output logic [DATA_W-1:0]  rdata,
  output logic               rdata_valid,
  output logic               done
);

  localparam int T_A   = (T_SU > T_PW) ? T_SU : T_PW;
  localparam int T_B   = (T_HD > T_REC) ? T_HD : T_REC;
  localparam int T_MAX = (T_A > T_B) ? T_A : T_B;
  localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [CNT_W-1:0]   LD_SU   = CNT_W'(T_SU - 1);
  localparam logic [CNT_W-1:0]   LD_PW   = CNT_W'(T_PW - 1);
  localparam logic [CNT_W-1:0]   LD_HD   = CNT_W'(T_HD - 1);
  localparam logic [CNT_W-1:0]   LD_REC  = CNT_W'(T_REC - 1);
  localparam logic [CNT_W-1:0]   CNT_Z   = {CNT_W{1'b0}};
  localparam logic [BURST_W-1:0] BEAT_1  = BURST_W'(1'b1);
  localparam logic [DATA_W-1:0]  DATA_Z  = {DATA_W{1'b0}};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR_SU = 3'd1,
    ADDR_PW = 3'd2,
    ADDR_HD = 3'd3,
    DATA_SU = 3'd4,
    DATA_PW = 3'd5,
    DATA_HD = 3'd6,
    RECOV   = 3'd7
  } state_t;

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s, cnt_dec_s;
  logic [DATA_W-1:0]  addr_r, addr_s;
  logic [DATA_W-1:0]  wdata_r, wdata_s;
  logic [BURST_W-1:0] beats_r, beats_s;
  logic               rw_r, rw_s;
  logic               cnt_zero_s, next_req_s, capture_s, done_s;
  logic               cs_s, rd_s, wr_s, ad_s, oe_s;
  logic [DATA_W-1:0]  out_s;

  // Next-state, shared phase counter and per-transfer context.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    addr_s     = addr_r;
    wdata_s    = wdata_r;
    beats_s    = beats_r;
    rw_s       = rw_r;
    next_req_s = 1'b0;
    capture_s  = 1'b0;
    cnt_zero_s = (cnt_r == CNT_Z);
    cnt_dec_s  = cnt_r - CNT_W'(1'b1);
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = ADDR_SU;
          cnt_s   = LD_SU;
          addr_s  = addr;
          rw_s    = rw;
          beats_s = (burst_len == {BURST_W{1'b0}}) ? BEAT_1 : burst_len;
        end else begin
          state_s = IDLE;
        end
      end
      ADDR_SU: begin
        if (cnt_zero_s) begin
          state_s = ADDR_PW;
          cnt_s   = LD_PW;
        end else begin
          cnt_s = cnt_dec_s;
        end
      end
      ADDR_PW: begin
        if (cnt_zero_s) begin
          state_s = ADDR_HD;
          cnt_s   = LD_HD;
        end else begin
          cnt_s = cnt_dec_s;
        end
      end
      ADDR_HD: begin
        if (cnt_zero_s) begin
          state_s = DATA_SU;
          cnt_s   = LD_SU;
          wdata_s = wdata;
        end else begin
          cnt_s = cnt_dec_s;
        end
      end
      DATA_SU: begin
        if (cnt_zero_s) begin
          state_s = DATA_PW;
          cnt_s   = LD_PW;
        end else begin
          cnt_s = cnt_dec_s;
        end
      end
      DATA_PW: begin
        if (cnt_zero_s) begin
          state_s   = DATA_HD;
          cnt_s     = LD_HD;
          capture_s = rw_r;
        end else begin
          cnt_s = cnt_dec_s;
        end
      end
      DATA_HD: begin
        if (cnt_zero_s) begin
          state_s = RECOV;
          cnt_s   = LD_REC;
        end else begin
          cnt_s = cnt_dec_s;
        end
      end
      RECOV: begin
        if (cnt_zero_s && (beats_r != BEAT_1)) begin
          state_s    = ADDR_SU;
          cnt_s      = LD_SU;
          addr_s     = addr_r + DATA_W'(1'b1);
          beats_s    = beats_r - BEAT_1;
          next_req_s = ~rw_r;
        end else if (cnt_zero_s) begin
          state_s = IDLE;
        end else begin
          cnt_s = cnt_dec_s;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_Z;
      end
    endcase
    // beats_r only changes on leaving RECOV, so it still describes the beat being entered here
    done_s = (state_s == RECOV) && (cnt_s == CNT_Z) && (beats_r == BEAT_1);
  end

  // Bus pin levels decoded from the state being entered, so the registered pins line up with it.
  always_comb begin
    cs_s  = 1'b1;
    rd_s  = 1'b1;
    wr_s  = 1'b1;
    ad_s  = 1'b1;
    oe_s  = 1'b0;
    out_s = DATA_Z;
    case (state_s)
      ADDR_SU, ADDR_PW, ADDR_HD: begin
        cs_s  = 1'b0;
        ad_s  = 1'b0;
        oe_s  = 1'b1;
        out_s = addr_s;
        if (state_s == ADDR_PW) begin
          wr_s = 1'b0;
        end else begin
          wr_s = 1'b1;
        end
      end
      DATA_SU, DATA_PW, DATA_HD: begin
        cs_s = 1'b0;
        ad_s = 1'b1;
        if (rw_s) begin
          oe_s  = 1'b0;
          out_s = DATA_Z;
          if (state_s == DATA_PW) begin
            rd_s = 1'b0;
          end else begin
            rd_s = 1'b1;
          end
        end else begin
          oe_s  = 1'b1;
          out_s = wdata_s;
          if (state_s == DATA_PW) begin
            wr_s = 1'b0;
          end else begin
            wr_s = 1'b1;
          end
        end
      end
      IDLE, RECOV: begin
        cs_s = 1'b1;
        oe_s = 1'b0;
      end
      default: begin
        cs_s = 1'b1;
        oe_s = 1'b0;
      end
    endcase
  end

  // State, context and all output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_Z;
      addr_r      <= DATA_Z;
      wdata_r     <= DATA_Z;
      beats_r     <= BEAT_1;
      rw_r        <= 1'b0;
      bus_out     <= DATA_Z;
      bus_oe      <= 1'b0;
      A_D         <= 1'b1;
      CS          <= 1'b1;
      RD          <= 1'b1;
      WR          <= 1'b1;
      busy        <= 1'b0;
      next_req    <= 1'b0;
      rdata       <= DATA_Z;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      addr_r      <= addr_s;
      wdata_r     <= wdata_s;
      beats_r     <= beats_s;
      rw_r        <= rw_s;
      bus_out     <= out_s;
      bus_oe      <= oe_s;
      A_D         <= ad_s;
      CS          <= cs_s;
      RD          <= rd_s;
      WR          <= wr_s;
      busy        <= (state_s != IDLE);
      next_req    <= next_req_s;
      rdata_valid <= capture_s;
      done        <= done_s;
      if (capture_s) begin
        rdata <= bus_in;
      end
    end
  end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Scoreboard bench for rtc_bus_sequencer: stimulus pushes expected per-transfer summaries,
// a negedge monitor measures each transfer and pops/compares when busy falls.
module tb_rtc_bus_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, rw;
  logic [7:0] addr, wdata, bus_in, bus_out, rdata;
  logic [3:0] burst_len;
  logic       bus_oe, A_D, CS, RD, WR, busy, next_req, rdata_valid, done;

  int n_tests = 0;
  int n_fail  = 0;
  int done_total = 0;

  typedef struct {
    int busy_cyc; int wr_low; int wr_win; int rd_low; int nreq; int beats;
    logic [7:0] first_addr; logic [7:0] last_addr; logic [7:0] wdata_last;
    int data_oe; int cs_high; int done_at; int done_cnt; int both_low;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] rd_q[$];

  rtc_bus_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr),
    .burst_len(burst_len), .wdata(wdata), .bus_in(bus_in), .bus_out(bus_out),
    .bus_oe(bus_oe), .A_D(A_D), .CS(CS), .RD(RD), .WR(WR), .busy(busy),
    .next_req(next_req), .rdata(rdata), .rdata_valid(rdata_valid), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(int bc, int wl, int ww, int rl, int nr, int bt,
                              logic [7:0] fa, logic [7:0] la, logic [7:0] wd, int doe, int csh);
    exp_t e;
    e.busy_cyc = bc; e.wr_low = wl; e.wr_win = ww; e.rd_low = rl; e.nreq = nr; e.beats = bt;
    e.first_addr = fa; e.last_addr = la; e.wdata_last = wd; e.data_oe = doe; e.cs_high = csh;
    e.done_at = bc; e.done_cnt = 1; e.both_low = 0;
    return e;
  endfunction

  // Monitor: measure the transfer in flight, compare against the scoreboard when busy falls.
  initial begin
    exp_t obs, e;
    logic prev_wr, prev_ad, prev_busy;
    obs = '{default: 0};
    prev_wr = 1'b1; prev_ad = 1'b1; prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        obs = '{default: 0};
        prev_wr = 1'b1; prev_ad = 1'b1; prev_busy = 1'b0;
      end else begin
        if (busy) begin
          obs.busy_cyc += 1;
          if (!WR) obs.wr_low += 1;
          if (!WR && prev_wr) obs.wr_win += 1;
          if (!RD) obs.rd_low += 1;
          if (!RD && !WR) obs.both_low += 1;
          if (next_req) obs.nreq += 1;
          if (!A_D && prev_ad) begin
            if (obs.beats == 0) obs.first_addr = bus_out;
            obs.last_addr = bus_out;
            obs.beats += 1;
          end
          if (A_D && !CS && !WR) obs.wdata_last = bus_out;
          if (A_D && !CS && bus_oe) obs.data_oe += 1;
          if (CS) obs.cs_high += 1;
        end
        if (done) begin
          obs.done_cnt += 1;
          obs.done_at = obs.busy_cyc;
          done_total++;
        end
        if (rdata_valid) begin
          if (rd_q.size() == 0) begin
            check("unexpected_rdata_valid", 32'd1, 32'd0);
          end else begin
            check("rdata", {24'h0, rdata}, {24'h0, rd_q.pop_front()});
          end
        end
        if (prev_busy && !busy) begin
          if (exp_q.size() == 0) begin
            check("unexpected_transfer", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("busy_cycles", obs.busy_cyc, e.busy_cyc);
            check("wr_low_cycles", obs.wr_low, e.wr_low);
            check("wr_windows", obs.wr_win, e.wr_win);
            check("rd_low_cycles", obs.rd_low, e.rd_low);
            check("next_req_pulses", obs.nreq, e.nreq);
            check("beats", obs.beats, e.beats);
            check("first_addr", {24'h0, obs.first_addr}, {24'h0, e.first_addr});
            check("last_addr", {24'h0, obs.last_addr}, {24'h0, e.last_addr});
            check("last_wdata", {24'h0, obs.wdata_last}, {24'h0, e.wdata_last});
            check("data_phase_oe_cycles", obs.data_oe, e.data_oe);
            check("cs_high_cycles", obs.cs_high, e.cs_high);
            check("done_busy_cycle", obs.done_at, e.done_at);
            check("done_pulses", obs.done_cnt, e.done_cnt);
            check("rd_wr_both_low", obs.both_low, e.both_low);
          end
          obs = '{default: 0};
        end
        prev_wr = WR; prev_ad = A_D; prev_busy = busy;
      end
    end
  end

  // Every stimulus cycle goes through here so wdata advances on next_req.
  task automatic tick();
    @(negedge clk);
    if (next_req) wdata = wdata + 8'h01;
  endtask

  task automatic issue_start(input logic r, input logic [7:0] a, input logic [3:0] bl);
    tick();
    start = 1'b1; rw = r; addr = a; burst_len = bl;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      if (!busy) ok = 1'b1;
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL wait_idle: busy still %0b, expected 0 within 300 cycles", busy);
    end
  endtask

  task automatic do_xfer(input logic r, input logic [7:0] a, input logic [3:0] bl,
                         input logic [7:0] wd, input logic [7:0] bi, input exp_t e);
    exp_q.push_back(e);
    wdata = wd; bus_in = bi;
    issue_start(r, a, bl);
    wait_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    reset = 1'b1; start = 1'b0; rw = 1'b0; addr = 8'h00; burst_len = 4'd0;
    wdata = 8'h00; bus_in = 8'h00;
    #2 reset = 1'b0;
    #1;
    check("rst_CS", CS, 1'b1);
    check("rst_RD", RD, 1'b1);
    check("rst_WR", WR, 1'b1);
    check("rst_A_D", A_D, 1'b1);
    check("rst_bus_oe", bus_oe, 1'b0);
    check("rst_bus_out", bus_out, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_pulses", {done, rdata_valid, next_req}, 3'b000);
    check("rst_rdata", rdata, 8'h00);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    do_xfer(1'b0, 8'h21, 4'd1, 8'h15, 8'h00, mk(19, 8, 2, 0, 0, 1, 8'h21, 8'h21, 8'h15, 8, 3));
    rd_q.push_back(8'h37);
    do_xfer(1'b1, 8'h22, 4'd1, 8'h00, 8'h37, mk(19, 4, 1, 4, 0, 1, 8'h22, 8'h22, 8'h00, 0, 3));
    do_xfer(1'b0, 8'hFE, 4'd3, 8'h40, 8'h00, mk(57, 24, 6, 0, 2, 3, 8'hFE, 8'h00, 8'h42, 24, 9));
    do_xfer(1'b0, 8'h10, 4'd0, 8'h55, 8'h00, mk(19, 8, 2, 0, 0, 1, 8'h10, 8'h10, 8'h55, 8, 3));
    rd_q.push_back(8'h5A);
    rd_q.push_back(8'h5A);
    do_xfer(1'b1, 8'h7F, 4'd2, 8'h00, 8'h5A, mk(38, 8, 2, 8, 0, 2, 8'h7F, 8'h80, 8'h00, 0, 6));

    // Abort a write in DATA_PW with reset; no scoreboard entry for it.
    wdata = 8'h99; bus_in = 8'h00;
    issue_start(1'b0, 8'h30, 4'd1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (busy && A_D && !WR) found = 1'b1;
    end
    check("reach_data_pw", found, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("abort_CS", CS, 1'b1);
    check("abort_WR", WR, 1'b1);
    check("abort_bus_oe", bus_oe, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_rdata", rdata, 8'h00);
    tick();
    tick();
    reset = 1'b1;
    do_xfer(1'b0, 8'h31, 4'd1, 8'h66, 8'h00, mk(19, 8, 2, 0, 0, 1, 8'h31, 8'h31, 8'h66, 8, 3));

    // Start while busy and start coincident with done must both be dropped.
    exp_q.push_back(mk(19, 8, 2, 0, 0, 1, 8'h50, 8'h50, 8'h77, 8, 3));
    wdata = 8'h77; bus_in = 8'h00;
    issue_start(1'b0, 8'h50, 4'd1);
    repeat (5) tick();
    start = 1'b1; rw = 1'b1; addr = 8'h99; burst_len = 4'd3;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (done) found = 1'b1;
    end
    check("reach_done", found, 1'b1);
    start = 1'b1; rw = 1'b1; addr = 8'hAA; burst_len = 4'd2;
    tick();
    start = 1'b0;
    check("start_at_done_busy", busy, 1'b0);
    repeat (30) tick();
    check("idle_busy", busy, 1'b0);
    check("idle_CS", CS, 1'b1);
    check("scoreboard_empty", exp_q.size(), 0);
    check("rdata_queue_empty", rd_q.size(), 0);
    check("total_done", done_total, 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
